// File: rtl/seq_detect_pkg.sv
// Shared constants and sizing helper for the parametrised sequence detector.
package seq_detect_pkg;

  // Legal range of the pattern length.
  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

  // Pattern loaded by reset when the default width is used; first bit is the MSB.
  localparam logic [3:0] DEFAULT_PAT4 = 4'b0101;

  // Number of bits needed to count 0..value-1 (ceil(log2(value))), minimum 1.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, cleared by CR.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CP,
  input  logic         CR,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step by one unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Count register with synchronous clear.
  always_ff @(posedge CP) begin
    if (CR) cnt_q <= '0;
    else    cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector: loadable N-bit pattern, optional overlap,
// input-valid gating, zero-latency match pulse and saturating match count.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int           N           = 4,
  parameter logic [N-1:0] DEFAULT_PAT = N'(DEFAULT_PAT4),
  parameter int           CNT_W       = 8
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             En,
  input  logic             Sin,
  input  logic             Load,
  input  logic [N-1:0]     Pat,
  input  logic             Overlap,
  output logic             Out,
  output logic [CNT_W-1:0] Match_cnt
);

  localparam int                FILL_W   = clog2(N);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(N - 1);

  if ((N < N_MIN) || (N > N_MAX)) begin : g_bad_n
    $error("seq_detect_param: N must lie between N_MIN and N_MAX");
  end

  logic [N-1:0]      pat_q,  pat_d;
  logic [N-2:0]      hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [N-1:0]      cand;
  logic              match;

  // Candidate word: stored history followed by the bit arriving now.
  assign cand  = {hist_q, Sin};
  assign match = !CR && En && !Load && (fill_q == FILL_MAX) && (cand == pat_q);
  assign Out   = match;

  // Next-state: Load wins over En; a non-overlapping match restarts the history.
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (Load) begin
      pat_d  = Pat;
      hist_d = '0;
      fill_d = '0;
    end else if (En) begin
      if (match && !Overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = cand[N-2:0];
        if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      end
    end
  end

  // State registers; reset restores the default pattern and empties the history.
  always_ff @(posedge CP) begin
    if (CR) begin
      pat_q  <= DEFAULT_PAT;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .CP  (CP),
    .CR  (CR),
    .inc (match),
    .q   (Match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench: two detector builds (8-bit and 2-bit counters) share stimulus.
module tb_seq_detect_param;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         CR = 1'b1, En = 1'b0, Sin = 1'b0, Load = 1'b0, Overlap = 1'b1;
  logic [N-1:0] Pat = '0;
  logic         out_a, out_b;
  logic [7:0]   cnt_a;
  logic [1:0]   cnt_b;

  int total = 0;
  int bad   = 0;

  // Reference model: recent accepted bits (oldest first), current pattern, match tallies.
  bit           mq[$];
  logic [N-1:0] mpat = 4'b0101;
  int           mcnt_a = 0;
  int           mcnt_b = 0;

  typedef struct {
    logic         cr, en, sin, ld;
    logic [N-1:0] pat;
    logic         ov;
    int           exp_out;
    int           exp_cnt;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  seq_detect_param #(.N(N), .DEFAULT_PAT(4'b0101), .CNT_W(8)) dut_a (
    .CP(clk), .CR(CR), .En(En), .Sin(Sin), .Load(Load), .Pat(Pat),
    .Overlap(Overlap), .Out(out_a), .Match_cnt(cnt_a)
  );

  seq_detect_param #(.N(N), .DEFAULT_PAT(4'b0101), .CNT_W(2)) dut_b (
    .CP(clk), .CR(CR), .En(En), .Sin(Sin), .Load(Load), .Pat(Pat),
    .Overlap(Overlap), .Out(out_b), .Match_cnt(cnt_b)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive after the falling edge, compare, then advance the model.
  // exp_* of -1 means only the model is consulted for that output.
  task automatic step(input logic cr, input logic en, input logic sin, input logic ld,
                      input logic [N-1:0] pat, input logic ov,
                      input int exp_out, input int exp_ca, input int exp_cb,
                      input string tag, input bit verbose);
    bit m;
    @(negedge clk);
    CR = cr; En = en; Sin = sin; Load = ld; Pat = pat; Overlap = ov;
    #1;
    m = 1'b0;
    if (!cr && en && !ld && (mq.size() >= N - 1)) begin
      m = (sin == mpat[0]);
      for (int i = 1; i < N; i++)
        if (mq[mq.size() - i] != mpat[i]) m = 1'b0;
    end
    check({tag, ".out_a"}, int'(out_a), int'(m));
    check({tag, ".out_b"}, int'(out_b), int'(m));
    check({tag, ".cnt_a"}, int'(cnt_a), mcnt_a);
    check({tag, ".cnt_b"}, int'(cnt_b), mcnt_b);
    if (exp_out >= 0) check({tag, ".out_exp"}, int'(out_a), exp_out);
    if (exp_ca  >= 0) check({tag, ".cnt_a_exp"}, int'(cnt_a), exp_ca);
    if (exp_cb  >= 0) check({tag, ".cnt_b_exp"}, int'(cnt_b), exp_cb);
    if (verbose)
      $display("%s cr=%0b en=%0b sin=%0b ld=%0b pat=%b ov=%0b out=%0b cnt=%0d cnt2=%0d",
               tag, cr, en, sin, ld, pat, ov, out_a, cnt_a, cnt_b);
    if (cr) begin
      mq.delete();
      mpat   = 4'b0101;
      mcnt_a = 0;
      mcnt_b = 0;
    end else if (ld) begin
      mq.delete();
      mpat = pat;
    end else if (en) begin
      if (m) begin
        if (mcnt_a < 255) mcnt_a++;
        if (mcnt_b < 3)   mcnt_b++;
      end
      if (m && !ov) mq.delete();
      else begin
        mq.push_back(sin);
        while (mq.size() > N - 1) void'(mq.pop_front());
      end
    end
  endtask

  task automatic add(input logic cr, input logic en, input logic sin, input logic ov,
                     input int eo, input int ec);
    vec_t v;
    v.cr = cr; v.en = en; v.sin = sin; v.ld = 1'b0; v.pat = '0; v.ov = ov;
    v.exp_out = eo; v.exp_cnt = ec;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 0, -1, -1, "rst", 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 0, -1, -1, "rst", 1'b1);
  endtask

  initial begin
    int nm;
    int sin_i;

    // Tables for the overlapping and non-overlapping basic streams.
    add(1, 1, 0, 1, 0, -1); add(1, 0, 0, 1, 0, -1);
    add(0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 1, 0, 0); add(0, 1, 1, 1, 0, 0); add(0, 1, 0, 1, 0, 0);
    add(0, 1, 1, 1, 1, 0); add(0, 1, 0, 1, 0, 1); add(0, 1, 1, 1, 1, 1);
    add(0, 0, 0, 1, 0, 2);
    add(1, 1, 1, 0, 0, -1); add(1, 0, 0, 0, 0, -1);
    add(0, 1, 0, 0, 0, 0); add(0, 1, 1, 0, 0, 0); add(0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0); add(0, 1, 0, 0, 0, 1); add(0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1); add(0, 1, 1, 0, 1, 1);
    add(0, 0, 1, 0, 0, 2);

    foreach (tbl[i])
      step(tbl[i].cr, tbl[i].en, tbl[i].sin, tbl[i].ld, tbl[i].pat, tbl[i].ov,
           tbl[i].exp_out, tbl[i].exp_cnt, tbl[i].exp_cnt, "tbl", 1'b1);

    // Load mid-stream discards history and that cycle's bit; new pattern 1101.
    do_reset();
    step(0, 1, 0, 0, '0, 1, 0, -1, -1, "ld", 1'b1);
    step(0, 1, 1, 0, '0, 1, 0, -1, -1, "ld", 1'b1);
    step(0, 1, 0, 0, '0, 1, 0, -1, -1, "ld", 1'b1);
    step(0, 1, 1, 1, 4'b1101, 1, 0, -1, -1, "ld.pulse", 1'b1);
    step(0, 1, 1, 0, '0, 1, 0, -1, -1, "ld", 1'b1);
    step(0, 1, 1, 0, '0, 1, 0, -1, -1, "ld", 1'b1);
    step(0, 1, 0, 0, '0, 1, 0, -1, -1, "ld", 1'b1);
    step(0, 1, 1, 0, '0, 1, 1, 0, 0, "ld.hit", 1'b1);
    step(0, 1, 0, 0, '0, 1, 0, 1, 1, "ld", 1'b1);
    step(0, 1, 1, 0, '0, 1, 0, -1, -1, "ld", 1'b1);
    step(0, 1, 0, 0, '0, 1, 0, -1, -1, "ld", 1'b1);
    step(0, 1, 1, 0, '0, 1, 0, 1, 1, "ld.old", 1'b1);

    // En gating with random Sin in the gaps.
    do_reset();
    for (int j = 0; j < 4; j++) begin
      step(0, 1, logic'(j % 2), 0, '0, 1, (j == 3) ? 1 : 0, -1, -1, "gate.en", 1'b1);
      for (int g = 0; g < 1 + int'($urandom_range(2)); g++)
        step(0, 0, logic'($urandom_range(1)), 0, '0, 1, 0, -1, -1, "gate.gap", 1'b1);
    end

    // Five overlapping matches: the 2-bit count saturates at 3.
    do_reset();
    nm = 0;
    for (int i = 0; i < 12; i++) begin
      sin_i = i % 2;
      step(0, 1, logic'(sin_i), 0, '0, 1, (i >= 3 && sin_i == 1) ? 1 : 0,
           nm, (nm > 3) ? 3 : nm, "sat", 1'b1);
      if (i >= 3 && sin_i == 1) nm++;
    end
    step(0, 0, 0, 0, '0, 1, 0, 5, 3, "sat.end", 1'b1);

    // Reset mid-pattern restores the default pattern and drops history.
    do_reset();
    step(0, 0, 0, 1, 4'b1101, 1, 0, -1, -1, "mrst", 1'b1);
    step(0, 1, 1, 0, '0, 1, 0, -1, -1, "mrst", 1'b1);
    step(0, 1, 1, 0, '0, 1, 0, -1, -1, "mrst", 1'b1);
    step(0, 1, 0, 0, '0, 1, 0, -1, -1, "mrst", 1'b1);
    step(1, 1, 1, 0, '0, 1, 0, -1, -1, "mrst.cr", 1'b1);
    step(0, 1, 1, 0, '0, 1, 0, 0, 0, "mrst.one", 1'b1);
    step(0, 1, 0, 0, '0, 1, 0, -1, -1, "mrst", 1'b1);
    step(0, 1, 1, 0, '0, 1, 0, -1, -1, "mrst", 1'b1);
    step(0, 1, 0, 0, '0, 1, 0, -1, -1, "mrst", 1'b1);
    step(0, 1, 1, 0, '0, 1, 1, 0, 0, "mrst.hit", 1'b1);
    step(0, 0, 0, 0, '0, 1, 0, 1, 1, "mrst.end", 1'b1);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      step(logic'($urandom_range(63) == 0), logic'($urandom_range(3) != 0),
           logic'($urandom_range(1)), logic'($urandom_range(31) == 0),
           4'($urandom_range(15)), logic'($urandom_range(1)),
           -1, -1, -1, "rnd", 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
